// File: rtl/regfile_bp.sv
// regfile_bp: DEPTH x WIDTH register file with two combinational read ports,
// one byte-enabled synchronous write port, optional write-to-read bypass,
// an optional hard-wired zero entry and a one-entry-per-cycle clear sweep.
// The array itself has no reset so it can map onto RAM.
module regfile_bp #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [AW-1:0]      rna,
    input  logic [AW-1:0]      rnb,
    output logic [WIDTH-1:0]   qa,
    output logic [WIDTH-1:0]   qb,
    input  logic [AW-1:0]      wn,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   d,
    input  logic               init_req,
    output logic               busy
);
    localparam int DEPTH = 1 << AW;
    localparam int NB    = WIDTH / 8;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state, state_nx;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] stored_w;
    logic [WIDTH-1:0] merged_w;
    logic             wr_acc;
    logic             zero_w;

    // entry 0 is read-only zero when ZERO_REG is set
    assign zero_w   = (ZERO_REG != 0) && (wn == '0);
    // a write lands only in IDLE with no clear of any kind pending this edge
    assign wr_acc   = (state == IDLE) && !clr && !init_req && we && !zero_w;
    assign stored_w = mem[wn];

    // byte merge of new data over the stored word; shared by write and bypass
    for (genvar i = 0; i < NB; i++) begin : g_merge
        assign merged_w[8*i +: 8] = be[i] ? d[8*i +: 8] : stored_w[8*i +: 8];
    end

    // state register; clr forces the sweep to (re)start
    always_ff @(posedge clk) begin
        if (clr) state <= SWEEP;
        else     state <= state_nx;
    end

    // next state: any clear request enters SWEEP, last entry returns to IDLE
    always_comb begin
        state_nx = state;
        if (init_req)
            state_nx = SWEEP;
        else if (state == SWEEP && ptr == '1)
            state_nx = IDLE;
    end

    // output decode
    always_comb begin
        busy = (state == SWEEP);
    end

    // sweep pointer; clr or init_req rewinds it, otherwise it walks during SWEEP
    always_ff @(posedge clk) begin
        if (clr || init_req)
            ptr <= '0;
        else if (state == SWEEP)
            ptr <= ptr + 1'b1;
    end

    // array update: a sweep clear or an accepted write, never both
    always_ff @(posedge clk) begin
        if (state == SWEEP && !clr)
            mem[ptr] <= '0;
        else if (wr_acc)
            mem[wn] <= merged_w;
    end

    // read port A: zero while clearing, zero entry, bypass, else array
    always_comb begin
        qa = mem[rna];
        if (busy || clr)
            qa = '0;
        else if ((ZERO_REG != 0) && (rna == '0))
            qa = '0;
        else if ((BYPASS != 0) && wr_acc && (rna == wn))
            qa = merged_w;
    end

    // read port B: same selection as port A
    always_comb begin
        qb = mem[rnb];
        if (busy || clr)
            qb = '0;
        else if ((ZERO_REG != 0) && (rnb == '0))
            qb = '0;
        else if ((BYPASS != 0) && wr_acc && (rnb == wn))
            qb = merged_w;
    end

endmodule

// File: tb/tb_regfile_bp.sv
// Bench for regfile_bp: default instance (zero reg + bypass) alongside a
// BYPASS=0 / ZERO_REG=0 instance on the same inputs.
module tb_regfile_bp;
    logic        clk = 1'b0;
    logic        clr, we, init_req;
    logic [4:0]  rna, rnb, wn;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] qa, qb, qa2, qb2;
    logic        busy, busy2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_bp dut (
        .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .wn(wn), .we(we), .be(be), .d(d), .init_req(init_req), .busy(busy)
    );

    regfile_bp #(.BYPASS(0), .ZERO_REG(0)) dut2 (
        .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(qa2), .qb(qb2),
        .wn(wn), .we(we), .be(be), .d(d), .init_req(init_req), .busy(busy2)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wn;
        logic [3:0]  be;
        logic [31:0] d;
        logic [4:0]  rna;
        logic [4:0]  rnb;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [31:0] qa2;
        logic [31:0] qb2;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // count busy cycles until release; reads must be zero throughout
    task automatic count_busy(input string name, input logic drop_we);
        int n = 0;
        while ((busy || busy2) && n < 100) begin
            #2;
            if (qa !== 32'h0 || qb !== 32'h0 || qa2 !== 32'h0 || qb2 !== 32'h0) begin
                tests++;
                fails++;
                $display("FAIL %s_read_zero: qa=%h qb=%h qa2=%h qb2=%h at busy cycle %0d",
                         name, qa, qb, qa2, qb2, n);
            end
            n++;
            step();
        end
        if (drop_we) we = 1'b0;
        chk({name, "_busy_cycles"}, 32'(n), 32'd32);
        chk({name, "_busy2_low"}, {31'b0, busy2}, 32'd0);
    endtask

    task automatic rd(input string name, input logic [4:0] a,
                      input logic [31:0] e1, input logic [31:0] e2);
        we  = 1'b0;
        rna = a;
        rnb = a;
        #2;
        chk({name, "_qa"},  qa,  e1);
        chk({name, "_qb"},  qb,  e1);
        chk({name, "_qa2"}, qa2, e2);
        chk({name, "_qb2"}, qb2, e2);
    endtask

    initial begin
        //            we  wn     be    d             rna    rnb    qa            qb            qa2           qb2
        vecs[0]  = '{1'b1, 5'd5,  4'hF, 32'hA00000AA, 5'd5,  5'd0,  32'hA00000AA, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b1, 5'd5,  4'h5, 32'h11223344, 5'd5,  5'd5,  32'hA0220044, 32'hA0220044, 32'hA00000AA, 32'hA00000AA};
        vecs[2]  = '{1'b0, 5'd0,  4'h0, 32'h0,        5'd5,  5'd0,  32'hA0220044, 32'h0,        32'hA0220044, 32'h0};
        vecs[3]  = '{1'b1, 5'd3,  4'hF, 32'h20000022, 5'd1,  5'd2,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b1, 5'd3,  4'h3, 32'h55667788, 5'd3,  5'd3,  32'h20007788, 32'h20007788, 32'h20000022, 32'h20000022};
        vecs[5]  = '{1'b0, 5'd0,  4'h0, 32'h0,        5'd3,  5'd5,  32'h20007788, 32'hA0220044, 32'h20007788, 32'hA0220044};
        vecs[6]  = '{1'b1, 5'd0,  4'hF, 32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[7]  = '{1'b0, 5'd0,  4'h0, 32'h0,        5'd0,  5'd3,  32'h0,        32'h20007788, 32'hFFFFFFFF, 32'h20007788};
        vecs[8]  = '{1'b1, 5'd9,  4'h0, 32'hDEADBEEF, 5'd9,  5'd0,  32'h0,        32'h0,        32'h0,        32'hFFFFFFFF};
        vecs[9]  = '{1'b0, 5'd0,  4'h0, 32'h0,        5'd9,  5'd0,  32'h0,        32'h0,        32'h0,        32'hFFFFFFFF};
        vecs[10] = '{1'b1, 5'd31, 4'hF, 32'hCAFEF00D, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 5'd0,  4'h0, 32'h0,        5'd31, 5'd0,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'hFFFFFFFF};

        clr = 1'b1; init_req = 1'b0; we = 1'b0; wn = '0; be = '0; d = '0;
        rna = 5'd5; rnb = 5'd6;

        // reset: clr for two edges, then count the sweep
        step();
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_qa_clr", qa, 32'h0);
        step();
        clr = 1'b0;
        count_busy("rst", 1'b0);
        for (int i = 0; i < 32; i++) rd($sformatf("post_rst_r%0d", i), 5'(i), 32'h0, 32'h0);

        // table vectors: combinational read before the edge, then write on edge
        for (int i = 0; i < 12; i++) begin
            we = vecs[i].we; wn = vecs[i].wn; be = vecs[i].be; d = vecs[i].d;
            rna = vecs[i].rna; rnb = vecs[i].rnb;
            #2;
            chk($sformatf("vec%0d_qa", i),  qa,  vecs[i].qa);
            chk($sformatf("vec%0d_qb", i),  qb,  vecs[i].qb);
            chk($sformatf("vec%0d_qa2", i), qa2, vecs[i].qa2);
            chk($sformatf("vec%0d_qb2", i), qb2, vecs[i].qb2);
            step();
        end
        we = 1'b0;

        // init_req from IDLE, restart at sweep cycle 10, writes while busy dropped
        init_req = 1'b1;
        #2;
        chk("init_req_idle_qa_busy0", {31'b0, busy}, 32'd0);
        step();
        init_req = 1'b0;
        chk("init_busy", {31'b0, busy}, 32'd1);
        we = 1'b1; wn = 5'd7; be = 4'hF; d = 32'h12345678; rna = 5'd7; rnb = 5'd7;
        for (int i = 0; i < 10; i++) step();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        count_busy("init", 1'b1);
        rd("init_r7", 5'd7, 32'h0, 32'h0);
        rd("init_r5", 5'd5, 32'h0, 32'h0);
        rd("init_r31", 5'd31, 32'h0, 32'h0);

        // steady writes, then clr mid-stream with a write in the same cycle
        we = 1'b1; be = 4'hF;
        wn = 5'd1; d = 32'h11111111; step();
        wn = 5'd2; d = 32'h22222222; step();
        we = 1'b0;
        rd("stream_r1", 5'd1, 32'h11111111, 32'h11111111);
        rd("stream_r2", 5'd2, 32'h22222222, 32'h22222222);
        we = 1'b1; wn = 5'd4; d = 32'h44444444; rna = 5'd4; rnb = 5'd1; clr = 1'b1;
        #2;
        chk("clr_cycle_qa", qa, 32'h0);
        chk("clr_cycle_qb2", qb2, 32'h0);
        step();
        clr = 1'b0; we = 1'b0;
        chk("clr_busy_next", {31'b0, busy}, 32'd1);
        count_busy("midclr", 1'b0);
        rd("midclr_r1", 5'd1, 32'h0, 32'h0);
        rd("midclr_r2", 5'd2, 32'h0, 32'h0);
        rd("midclr_r4", 5'd4, 32'h0, 32'h0);

        // first write after sweep lands on the edge where busy is already 0
        we = 1'b1; wn = 5'd4; d = 32'h0BADF00D; be = 4'hF; step();
        rd("post_sweep_wr", 5'd4, 32'h0BADF00D, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
